// File: rtl/spi_pkg.sv
// spi_pkg: FSM encoding and shared constants for the SPI master arbiter
package spi_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;
  localparam int MIN_CLK_DIV = 2;
  localparam int BYTE_W = 8;
endpackage

// File: rtl/spi_rr_arbiter.sv
// spi_rr_arbiter: two-way round-robin choice with a last-grant register
module spi_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       any,
  output logic       gnt_id
);
  logic last;
  assign any = |req;
  assign gnt_id = req[1] & (~req[0] | ~last);
  // remember who won so a tie goes to the other requester next time
  always_ff @(posedge clk)
    if (rst) last <= 1'b1;
    else if (take && any) last <= gnt_id;
endmodule

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: single-byte SPI master (CPOL=0, LSB first) shared by two requesters
module spi_master_arbiter
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic [BYTE_W-1:0] data0_bi,
  input  logic              req1_i,
  input  logic [BYTE_W-1:0] data1_bi,
  output logic              busy_o,
  output logic              done_o,
  output logic              done_id_o,
  output logic [BYTE_W-1:0] rdata_bo,
  output logic              spi_sclk_o,
  output logic              spi_mosi_o,
  input  logic              spi_miso_i,
  output logic              spi_cs_o
);
  localparam logic [7:0] RELOAD = 8'((CLK_DIV < MIN_CLK_DIV ? MIN_CLK_DIV : CLK_DIV) - 1);
  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] bcnt;
  logic [BYTE_W-1:0] tx, rx;
  logic id, gnt_any, gnt_id, grant, phase_end, last_bit;
  assign phase_end = cnt == 8'd0;
  assign grant = state == IDLE && gnt_any;
  assign last_bit = state == LOW && phase_end && bcnt == 3'd7;
  spi_rr_arbiter u_rr (
    .clk   (clk_i),
    .rst   (rst_i),
    .req   ({req1_i, req0_i}),
    .take  (grant),
    .any   (gnt_any),
    .gnt_id(gnt_id)
  );
  // state register and half-period counter
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  // next state, counter reload on every phase entry, and pin levels per state
  always_comb begin
    state_n = state;
    cnt_n = (grant || (state != IDLE && phase_end)) ? RELOAD : (state == IDLE ? cnt : cnt - 8'd1);
    busy_o = state != IDLE;
    spi_cs_o = state == IDLE || state == GAP;
    spi_sclk_o = state == HIGH;
    spi_mosi_o = !spi_cs_o & tx[0];
    case (state)
      IDLE:    state_n = grant ? SETUP : IDLE;
      SETUP:   state_n = phase_end ? HIGH : SETUP;
      HIGH:    state_n = phase_end ? LOW : HIGH;
      LOW:     state_n = !phase_end ? LOW : (bcnt == 3'd7 ? GAP : HIGH);
      GAP:     state_n = phase_end ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  // datapath: latch on grant, sample/shift at end of HIGH, publish entering GAP
  always_ff @(posedge clk_i)
    if (rst_i) begin
      tx <= '0;
      rx <= '0;
      id <= 1'b0;
      bcnt <= '0;
      done_o <= 1'b0;
      done_id_o <= 1'b0;
      rdata_bo <= '0;
    end else begin
      done_o <= last_bit;
      if (grant) begin
        tx <= gnt_id ? data1_bi : data0_bi;
        id <= gnt_id;
        bcnt <= '0;
      end
      if (state == HIGH && phase_end) begin
        tx <= tx >> 1;
        rx <= {spi_miso_i, rx[BYTE_W-1:1]};
      end
      if (state == LOW && phase_end) bcnt <= bcnt + 3'd1;
      if (last_bit) begin
        rdata_bo <= rx;
        done_id_o <= id;
      end
    end
endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb_spi_master_arbiter: scoreboard bench for the SPI master arbiter at CLK_DIV 4 and 2
module tb_spi_master_arbiter;
  typedef struct {logic id; logic [7:0] tx; logic [7:0] rx;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_checks = 0, n_fail = 0;
  logic clk = 0, rst = 0;
  logic req0 = 0, req1 = 0, busy, done, done_id, sclk, mosi, miso, cs;
  logic [7:0] data0 = 0, data1 = 0, rdata;
  logic req0b = 0, req1b = 0, busy2, done2, done_id2, sclk2, mosi2, cs2;
  logic [7:0] data0b = 0, data1b = 0, rdata2;
  logic [7:0] sbyte = 0, mosi_cap = 0;
  int sidx = 0, rises = 0;
  logic psclk = 0, pcs = 1;

  always #5 clk = ~clk;

  spi_master_arbiter #(.CLK_DIV(4)) dut (
    .clk_i(clk), .rst_i(rst), .req0_i(req0), .data0_bi(data0), .req1_i(req1), .data1_bi(data1),
    .busy_o(busy), .done_o(done), .done_id_o(done_id), .rdata_bo(rdata),
    .spi_sclk_o(sclk), .spi_mosi_o(mosi), .spi_miso_i(miso), .spi_cs_o(cs)
  );
  spi_master_arbiter #(.CLK_DIV(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .req0_i(req0b), .data0_bi(data0b), .req1_i(req1b), .data1_bi(data1b),
    .busy_o(busy2), .done_o(done2), .done_id_o(done_id2), .rdata_bo(rdata2),
    .spi_sclk_o(sclk2), .spi_mosi_o(mosi2), .spi_miso_i(mosi2), .spi_cs_o(cs2)
  );

  assign miso = sbyte[sidx[2:0]];

  // slave model and MOSI capture: shift on falling SCLK, record MOSI at rising SCLK
  always @(negedge clk) begin
    if (!cs && pcs) begin
      sidx <= 0;
      rises <= 0;
    end else begin
      if (!sclk && psclk) sidx <= sidx + 1;
      if (sclk && !psclk) begin
        rises <= rises + 1;
        mosi_cap <= {mosi, mosi_cap[7:1]};
      end
    end
    psclk <= sclk;
    pcs <= cs;
  end

  task automatic do_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = -1;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (done) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic watch_idle(input int limit, output int dones, output int starts);
    logic pb;
    pb = busy;
    dones = 0;
    starts = 0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (done) dones++;
      if (busy && !pb) starts++;
      pb = busy;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (cs !== 1'b1 || cs2 !== 1'b1) begin n_fail++; $display("FAIL reset_cs: got %b/%b expected 1/1", cs, cs2); end
    n_checks++; if (sclk !== 1'b0 || mosi !== 1'b0) begin n_fail++; $display("FAIL reset_pins: got sclk %b mosi %b expected 0 0", sclk, mosi); end
    n_checks++; if (rdata !== 8'h00 || done_id !== 1'b0) begin n_fail++; $display("FAIL reset_result: got %h/%b expected 00/0", rdata, done_id); end
  endtask

  task automatic test_single();
    int cyc, k;
    data0 = 8'hA5;
    sbyte = 8'h3C;
    req0 = 1;
    sb.push_back('{1'b0, 8'hA5, 8'h3C});
    wait_done(200, cyc);
    req0 = 0;
    e = sb.pop_front();
    n_checks++; if (cyc !== 69) begin n_fail++; $display("FAIL single_latency: got %0d expected 69", cyc); end
    n_checks++; if (done_id !== e.id) begin n_fail++; $display("FAIL single_id: got %b expected %b", done_id, e.id); end
    n_checks++; if (rdata !== e.rx) begin n_fail++; $display("FAIL single_rdata: got %h expected %h", rdata, e.rx); end
    n_checks++; if (mosi_cap !== e.tx) begin n_fail++; $display("FAIL single_mosi: got %h expected %h", mosi_cap, e.tx); end
    n_checks++; if (rises !== 8) begin n_fail++; $display("FAIL single_pulses: got %0d expected 8", rises); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || cs !== 1'b1) begin n_fail++; $display("FAIL single_gap: got done %b cs %b expected 0 1", done, cs); end
    k = 1;
    while (busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_checks++; if (k !== 4) begin n_fail++; $display("FAIL single_gap_len: got %0d expected 4", k); end
  endtask

  task automatic test_round_robin();
    int cyc;
    do_reset();
    data0 = 8'h11;
    data1 = 8'h22;
    sbyte = 8'hC5;
    for (int i = 0; i < 4; i++) sb.push_back('{1'(i % 2), (i % 2) ? 8'h22 : 8'h11, 8'hC5});
    req0 = 1;
    req1 = 1;
    for (int i = 0; i < 4; i++) begin
      wait_done(200, cyc);
      if (i == 3) begin
        req0 = 0;
        req1 = 0;
      end
      e = sb.pop_front();
      n_checks++; if (cyc !== (i == 0 ? 69 : 73)) begin n_fail++; $display("FAIL rr_period[%0d]: got %0d expected %0d", i, cyc, i == 0 ? 69 : 73); end
      n_checks++; if (done_id !== e.id) begin n_fail++; $display("FAIL rr_id[%0d]: got %b expected %b", i, done_id, e.id); end
      n_checks++; if (rdata !== e.rx || mosi_cap !== e.tx) begin n_fail++; $display("FAIL rr_data[%0d]: got rx %h tx %h expected %h %h", i, rdata, mosi_cap, e.rx, e.tx); end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_div2();
    int bad_cs = 0, bad_sclk = 0, cs_low = 0, r = 0, dk = -1, bk = -1;
    logic p = 0, exp_cs, exp_sclk;
    logic [7:0] got_rx = 0;
    logic got_id = 0;
    data1b = 8'hFF;
    req1b = 1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      exp_cs = !(k >= 1 && k <= 34);
      exp_sclk = k >= 3 && k <= 34 && ((k - 3) % 4) < 2;
      if (cs2 !== exp_cs) bad_cs++;
      if (sclk2 !== exp_sclk) bad_sclk++;
      if (!cs2) cs_low++;
      if (sclk2 && !p) r++;
      p = sclk2;
      if (done2) begin
        dk = k;
        got_rx = rdata2;
        got_id = done_id2;
        req1b = 0;
      end
      if (!busy2 && bk < 0) bk = k;
    end
    n_checks++; if (bad_cs !== 0 || cs_low !== 34) begin n_fail++; $display("FAIL div2_cs: got %0d bad, %0d low expected 0, 34", bad_cs, cs_low); end
    n_checks++; if (bad_sclk !== 0 || r !== 8) begin n_fail++; $display("FAIL div2_sclk: got %0d bad, %0d pulses expected 0, 8", bad_sclk, r); end
    n_checks++; if (dk !== 35) begin n_fail++; $display("FAIL div2_done: got %0d expected 35", dk); end
    n_checks++; if (bk !== 37) begin n_fail++; $display("FAIL div2_idle: got %0d expected 37", bk); end
    n_checks++; if (got_rx !== 8'hFF || got_id !== 1'b1) begin n_fail++; $display("FAIL div2_result: got %h/%b expected ff/1", got_rx, got_id); end
  endtask

  task automatic test_reset_abort();
    int r = 0, cyc, dones, starts;
    logic p = 0;
    data0 = 8'h5A;
    sbyte = 8'h3C;
    req0 = 1;
    for (int n = 0; n < 200 && r < 4; n++) begin
      @(negedge clk);
      if (sclk && !p) r++;
      p = sclk;
    end
    rst = 1;
    req0 = 0;
    @(negedge clk);
    rst = 0;
    n_checks++; if (r !== 4) begin n_fail++; $display("FAIL abort_reach: got %0d expected 4", r); end
    n_checks++; if (cs !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_pins: got cs %b sclk %b busy %b expected 1 0 0", cs, sclk, busy); end
    n_checks++; if (done !== 1'b0 || rdata !== 8'h00) begin n_fail++; $display("FAIL abort_result: got %b/%h expected 0/00", done, rdata); end
    watch_idle(80, dones, starts);
    n_checks++; if (dones !== 0 || starts !== 0) begin n_fail++; $display("FAIL abort_quiet: got %0d dones %0d starts expected 0 0", dones, starts); end
    data1 = 8'hC3;
    sbyte = 8'h96;
    req1 = 1;
    sb.push_back('{1'b1, 8'hC3, 8'h96});
    @(negedge clk);
    n_checks++; if (cs !== 1'b0 || sclk !== 1'b0 || mosi !== 1'b1) begin n_fail++; $display("FAIL abort_setup: got cs %b sclk %b mosi %b expected 0 0 1", cs, sclk, mosi); end
    wait_done(200, cyc);
    req1 = 0;
    e = sb.pop_front();
    n_checks++; if (cyc !== 68) begin n_fail++; $display("FAIL abort_latency: got %0d expected 68", cyc); end
    n_checks++; if (done_id !== e.id || rdata !== e.rx || mosi_cap !== e.tx) begin n_fail++; $display("FAIL abort_next: got %b %h %h expected %b %h %h", done_id, rdata, mosi_cap, e.id, e.rx, e.tx); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_req_drop();
    int cyc, dones, starts;
    data0 = 8'h0F;
    sbyte = 8'hF0;
    req0 = 1;
    sb.push_back('{1'b0, 8'h0F, 8'hF0});
    repeat (20) @(negedge clk);
    req0 = 0;
    data0 = 8'hFF;
    wait_done(200, cyc);
    e = sb.pop_front();
    n_checks++; if (cyc !== 49) begin n_fail++; $display("FAIL drop_latency: got %0d expected 49", cyc); end
    n_checks++; if (done_id !== e.id || rdata !== e.rx || mosi_cap !== e.tx) begin n_fail++; $display("FAIL drop_result: got %b %h %h expected %b %h %h", done_id, rdata, mosi_cap, e.id, e.rx, e.tx); end
    watch_idle(120, dones, starts);
    n_checks++; if (dones !== 0 || starts !== 0) begin n_fail++; $display("FAIL drop_regrant: got %0d dones %0d starts expected 0 0", dones, starts); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_div2();
    test_reset_abort();
    test_req_drop();
    n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL scoreboard_left: got %0d expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/spi_master_arbiter.md
SPI_MASTER_ARBITER -- requirements
Module: spi_master_arbiter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period and CS setup/gap length in clk_i cycles; legal range 2..255.
REQ-002 SHALL have port clk_i, input, 1: single system clock; all logic on rising edge.
REQ-003 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port req0_i, input, 1: requester 0 transaction request, level, held until done.
REQ-005 SHALL have port data0_bi, input, 8: requester 0 byte to transmit.
REQ-006 SHALL have port req1_i, input, 1: requester 1 transaction request.
REQ-007 SHALL have port data1_bi, input, 8: requester 1 byte to transmit.
REQ-008 SHALL have port busy_o, output, 1: transaction in progress (any state but IDLE).
REQ-009 SHALL have port done_o, output, 1: one-cycle pulse, transaction complete.
REQ-010 SHALL have port done_id_o, output, 1: requester served by the completing transaction; valid with done_o.
REQ-011 SHALL have port rdata_bo, output, 8: byte received from MISO; valid from done_o until next done_o.
REQ-012 SHALL have port spi_sclk_o, output, 1: SPI clock, CPOL=0.
REQ-013 SHALL have port spi_mosi_o, output, 1: master-out data, LSB first.
REQ-014 SHALL have port spi_miso_i, input, 1: slave-out data, LSB first.
REQ-015 SHALL have port spi_cs_o, output, 1: chip select, active-low.

Function
REQ-016 SHALL be an FSM with states IDLE, SETUP, HIGH, LOW, GAP; D = CLK_DIV.
REQ-017 In IDLE with any request, SHALL grant one requester, latch its data byte and id, and enter SETUP next cycle.
REQ-018 Arbitration SHALL be two-way round robin: single request wins; on both, winner is the requester not granted last; last-grant resets to 1, so req0 wins first.
REQ-019 SETUP SHALL last D cycles: cs_o=0, sclk_o=0, mosi_o=bit 0 of the latched byte.
REQ-020 HIGH SHALL last D cycles with sclk_o=1; miso_i SHALL be sampled on the last HIGH cycle into bit 7 of the receive shift register, shifting right.
REQ-021 LOW SHALL last D cycles with sclk_o=0; mosi_o SHALL advance to the next bit on the first LOW cycle; bit counter increments on LOW exit.
REQ-022 After the 8th LOW phase, the FSM SHALL enter GAP with cs_o=1, sclk_o=0, mosi_o=0 for D cycles, then return to IDLE.
REQ-023 done_o SHALL pulse on the first GAP cycle, with rdata_bo and done_id_o updated the same cycle.
REQ-024 Grant-to-IDLE SHALL be exactly 1+18*D cycles; done_o SHALL occur 1+17*D cycles after the grant cycle.
REQ-025 Requests asserted or dropped while busy SHALL NOT affect the current transaction; a new grant is decided only in IDLE.
REQ-026 A requester still asserting req in the IDLE cycle after its done SHALL be treated as a new request, subject to round robin.
REQ-027 The half-period counter SHALL be 8 bits wide and reload to D-1 on every phase entry.

Reset
REQ-028 On rst_i=1 at a clock edge, SHALL enter IDLE with cs_o=1, sclk_o=0, mosi_o=0, busy_o=0, done_o=0, done_id_o=0, rdata_bo=0, counters=0, last-grant=1.
REQ-029 Reset mid-transaction SHALL abort it without a done_o pulse; cs_o SHALL be 1 from the next cycle.

Structure
REQ-030 Package spi_pkg SHALL hold the FSM state encoding, the minimum CLK_DIV value, and the byte-width constant 8.
REQ-031 The round-robin choice SHALL be a sub-module, spi_rr_arbiter (2 requests, last-grant register, grant-id output).

Verification
REQ-032 D=4, req0 with data 0xA5, loopback slave returning 0x3C -> MOSI shows bits 1,0,1,0,0,1,0,1 at rising edges; done_o at grant+69, done_id_o=0, rdata_bo=0x3C.
REQ-033 req0 and req1 asserted together and held -> grants alternate 0,1,0,1; no requester is served twice in a row.
REQ-034 D=2, only req1 with data 0xFF -> cs_o low for 17*2 cycles, 8 sclk pulses each 2 high / 2 low, then cs_o high for 2 cycles.
REQ-035 rst_i asserted during the 4th HIGH phase -> cs_o=1 and sclk_o=0 next cycle, no done_o, next request starts a clean SETUP.
REQ-036 req0 dropped mid-transaction -> transaction completes, done_o pulses, and no further grant to requester 0.
